// File: rtl/conv3x3_rgb_engine.sv
// conv3x3_rgb_engine: programmable 3x3 convolution over packed RGB windows.
// Three-stage pipeline: per-tap products, signed accumulate, round/shift/clamp.
// Coefficients and shift live in a shadow bank; commit copies them to the
// active bank that stage 1 samples, so a kernel change never splits a pixel.
// Optional feature macro: CONV_BYPASS_EN adds a per-pixel 'bypass' input that
// forwards the center pixel unfiltered with the same latency.
//
// Handshake: valid-only stream, no ready. A window is accepted on every clock
// edge where valid_in=1; the matching result appears with valid_out=1 exactly
// three edges later. pixel_out/clip_out hold their last value while
// valid_out=0.
module conv3x3_rgb_engine #(
   parameter int CH_W   = 4,
   parameter int COEF_W = 8,
   parameter int ACC_W  = CH_W + COEF_W + 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     valid_in,
   input  logic [27*CH_W-1:0]       window_in,
   input  logic                     last_in,
   input  logic                     coef_wr,
   input  logic [3:0]               coef_idx,
   input  logic signed [COEF_W-1:0] coef_data,
   input  logic                     shift_wr,
   input  logic [3:0]               shift_data,
   input  logic                     commit,
`ifdef CONV_BYPASS_EN
   input  logic                     bypass,
`endif
   output logic                     valid_out,
   output logic [3*CH_W-1:0]        pixel_out,
   output logic                     last_out,
   output logic                     clip_out,
   output logic                     coef_dirty
);

   localparam int PIX_W  = 3 * CH_W;
   localparam int PROD_W = CH_W + COEF_W + 1;
   localparam int RND_W  = ACC_W + 1;
   localparam logic signed [RND_W-1:0] RND_ONE = RND_W'(1);
   localparam logic signed [RND_W-1:0] CH_MAX  = RND_W'((1 << CH_W) - 1);
   localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1);

   typedef logic signed [COEF_W-1:0] coef_t;

   logic byp_in;
`ifdef CONV_BYPASS_EN
   assign byp_in = bypass;
`else
   assign byp_in = 1'b0;
`endif

   // coefficient banks
   coef_t      shadow_coef_q [9];
   coef_t      shadow_coef_d [9];
   coef_t      active_coef_q [9];
   coef_t      active_coef_d [9];
   logic [3:0] shadow_shift_q, shadow_shift_d;
   logic [3:0] active_shift_q, active_shift_d;
   logic       dirty_q, dirty_d;

   // stage 1
   logic signed [PROD_W-1:0] prod_q [3][9];
   logic signed [PROD_W-1:0] prod_d [3][9];
   logic                     s1_valid_q, s1_last_q, s1_byp_q;
   logic [3:0]               s1_shift_q;
   logic [PIX_W-1:0]         s1_center_q;

   // stage 2
   logic signed [ACC_W-1:0]  acc_q [3];
   logic signed [ACC_W-1:0]  acc_d [3];
   logic                     s2_valid_q, s2_last_q, s2_byp_q;
   logic [3:0]               s2_shift_q;
   logic [PIX_W-1:0]         s2_center_q;

   // stage 3 / outputs
   logic                     valid_out_q, last_out_q;
   logic                     clip_out_q, clip_out_d;
   logic [PIX_W-1:0]         pixel_out_q, pixel_out_d;

   logic                     coef_accept;
   logic                     any_write;

   // Shadow writes, commit copy (pre-write shadow) and dirty tracking.
   always_comb begin
      coef_accept    = coef_wr && (coef_idx <= 4'd8);
      any_write      = coef_accept || shift_wr;
      shadow_coef_d  = shadow_coef_q;
      shadow_shift_d = shadow_shift_q;
      active_coef_d  = active_coef_q;
      active_shift_d = active_shift_q;
      dirty_d        = dirty_q;
      if (commit) begin
         active_coef_d  = shadow_coef_q;
         active_shift_d = shadow_shift_q;
         dirty_d        = 1'b0;
      end
      if (coef_accept) begin
         shadow_coef_d[coef_idx] = coef_data;
      end
      if (shift_wr) begin
         shadow_shift_d = shift_data;
      end
      if (any_write) begin
         dirty_d = 1'b1;
      end
   end

   // Stage 1: nine signed products per channel against the active kernel.
   always_comb begin
      logic signed [PROD_W-1:0] pix_ext;
      logic signed [PROD_W-1:0] coef_ext;
      pix_ext  = '0;
      coef_ext = '0;
      for (int c = 0; c < 3; c++) begin
         for (int k = 0; k < 9; k++) begin
            pix_ext  = {{(COEF_W+1){1'b0}}, window_in[k*PIX_W + (2-c)*CH_W +: CH_W]};
            coef_ext = {{(CH_W+1){active_coef_q[k][COEF_W-1]}}, active_coef_q[k]};
            prod_d[c][k] = pix_ext * coef_ext;
         end
      end
   end

   // Stage 2: signed sum of the nine products per channel.
   always_comb begin
      for (int c = 0; c < 3; c++) begin
         acc_d[c] = '0;
         for (int k = 0; k < 9; k++) begin
            acc_d[c] = acc_d[c] + {{(ACC_W-PROD_W){prod_q[c][k][PROD_W-1]}}, prod_q[c][k]};
         end
      end
   end

   // Stage 3: round half up, arithmetic shift, clamp to channel range.
   always_comb begin
      logic signed [RND_W-1:0] rnd_add;
      logic signed [RND_W-1:0] rounded;
      logic signed [RND_W-1:0] shifted;
      logic                    sat;
      rnd_add     = '0;
      rounded     = '0;
      shifted     = '0;
      sat         = 1'b0;
      pixel_out_d = pixel_out_q;
      clip_out_d  = clip_out_q;
      if (s2_valid_q) begin
         clip_out_d = 1'b0;
         for (int c = 0; c < 3; c++) begin
            rnd_add = (s2_shift_q != 4'd0) ? (RND_ONE << (s2_shift_q - 4'd1)) : '0;
            rounded = {acc_q[c][ACC_W-1], acc_q[c]} + rnd_add;
            shifted = rounded >>> s2_shift_q;
            sat     = 1'b1;
            if (shifted[RND_W-1]) begin
               pixel_out_d[(2-c)*CH_W +: CH_W] = '0;
            end else if (shifted > CH_MAX) begin
               pixel_out_d[(2-c)*CH_W +: CH_W] = '1;
            end else begin
               pixel_out_d[(2-c)*CH_W +: CH_W] = shifted[CH_W-1:0];
               sat = 1'b0;
            end
            clip_out_d = clip_out_d | sat;
         end
         if (s2_byp_q) begin
            pixel_out_d = s2_center_q;
            clip_out_d  = 1'b0;
         end
      end
   end

   // All state: banks reset to identity kernel, pipeline flushed on reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < 9; k++) begin
            shadow_coef_q[k] <= (k == 8) ? COEF_ONE : '0;
            active_coef_q[k] <= (k == 8) ? COEF_ONE : '0;
            for (int c = 0; c < 3; c++) begin
               prod_q[c][k] <= '0;
            end
         end
         for (int c = 0; c < 3; c++) begin
            acc_q[c] <= '0;
         end
         shadow_shift_q <= '0;
         active_shift_q <= '0;
         dirty_q        <= 1'b0;
         s1_valid_q     <= 1'b0;
         s1_last_q      <= 1'b0;
         s1_byp_q       <= 1'b0;
         s1_shift_q     <= '0;
         s1_center_q    <= '0;
         s2_valid_q     <= 1'b0;
         s2_last_q      <= 1'b0;
         s2_byp_q       <= 1'b0;
         s2_shift_q     <= '0;
         s2_center_q    <= '0;
         valid_out_q    <= 1'b0;
         last_out_q     <= 1'b0;
         clip_out_q     <= 1'b0;
         pixel_out_q    <= '0;
      end else begin
         shadow_coef_q  <= shadow_coef_d;
         active_coef_q  <= active_coef_d;
         shadow_shift_q <= shadow_shift_d;
         active_shift_q <= active_shift_d;
         dirty_q        <= dirty_d;
         prod_q         <= prod_d;
         s1_valid_q     <= valid_in;
         s1_last_q      <= last_in;
         s1_byp_q       <= byp_in;
         s1_shift_q     <= active_shift_q;
         s1_center_q    <= window_in[8*PIX_W +: PIX_W];
         acc_q          <= acc_d;
         s2_valid_q     <= s1_valid_q;
         s2_last_q      <= s1_last_q;
         s2_byp_q       <= s1_byp_q;
         s2_shift_q     <= s1_shift_q;
         s2_center_q    <= s1_center_q;
         valid_out_q    <= s2_valid_q;
         last_out_q     <= s2_last_q;
         clip_out_q     <= clip_out_d;
         pixel_out_q    <= pixel_out_d;
      end
   end

   assign valid_out  = valid_out_q;
   assign last_out   = last_out_q;
   assign clip_out   = clip_out_q;
   assign pixel_out  = pixel_out_q;
   assign coef_dirty = dirty_q;

endmodule

// File: tb/tb_conv3x3_rgb_engine.sv
// Bench for conv3x3_rgb_engine: directed kernel cases plus a random stream,
// checked against an integer reference of the filter and the coefficient banks.
module tb_conv3x3_rgb_engine;

   localparam int CH_W = 4;
   localparam int W    = 30;   // {due[15:0], last, clip, pixel[11:0]}

   logic         clk = 1'b0;
   logic         reset_n;
   logic         valid_in;
   logic [107:0] window_in;
   logic         last_in;
   logic         coef_wr;
   logic [3:0]   coef_idx;
   logic [7:0]   coef_data;
   logic         shift_wr;
   logic [3:0]   shift_data;
   logic         commit;
   logic         byp;
   logic         valid_out;
   logic [11:0]  pixel_out;
   logic         last_out;
   logic         clip_out;
   logic         coef_dirty;

   int           n_cmp = 0;
   int           n_err = 0;
   int           cyc   = 0;
   logic [W-1:0] exp_q[$];

   // reference banks
   int           sh_coef[9];
   int           ac_coef[9];
   int           sh_shift;
   int           ac_shift;
   bit           m_dirty;

   // clock / reset
   always #5 clk = ~clk;

   conv3x3_rgb_engine #(.CH_W(CH_W), .COEF_W(8)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .valid_in   (valid_in),
      .window_in  (window_in),
      .last_in    (last_in),
      .coef_wr    (coef_wr),
      .coef_idx   (coef_idx),
      .coef_data  (coef_data),
      .shift_wr   (shift_wr),
      .shift_data (shift_data),
      .commit     (commit),
`ifdef CONV_BYPASS_EN
      .bypass     (byp),
`endif
      .valid_out  (valid_out),
      .pixel_out  (pixel_out),
      .last_out   (last_out),
      .clip_out   (clip_out),
      .coef_dirty (coef_dirty)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   // reference filter: returns {clip, pixel}
   function automatic logic [12:0] ref_pix(input logic [107:0] w, input logic b);
      logic [11:0] p;
      logic        clip;
      int          s;
      p    = '0;
      clip = 1'b0;
      if (b) return {1'b0, w[107:96]};
      for (int c = 0; c < 3; c++) begin
         s = 0;
         for (int k = 0; k < 9; k++) s += ac_coef[k] * int'(w[k*12 + (2-c)*4 +: 4]);
         if (ac_shift > 0) s += (1 << (ac_shift - 1));
         s = s >>> ac_shift;
         if (s < 0) begin s = 0; clip = 1'b1; end
         else if (s > 15) begin s = 15; clip = 1'b1; end
         p[(2-c)*4 +: 4] = 4'(s);
      end
      return {clip, p};
   endfunction

   function automatic logic [107:0] mk_win(input logic [11:0] center, input logic [11:0] nb, input bit rnd);
      logic [107:0] w;
      w = '0;
      for (int k = 0; k < 8; k++) w[k*12 +: 12] = rnd ? 12'($urandom) : nb;
      w[96 +: 12] = center;
      return w;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 9; k++) begin
         sh_coef[k] = (k == 8) ? 1 : 0;
         ac_coef[k] = (k == 8) ? 1 : 0;
      end
      sh_shift = 0;
      ac_shift = 0;
      m_dirty  = 1'b0;
      exp_q.delete();
   endtask

   task automatic idle_inputs();
      valid_in = 1'b0; last_in = 1'b0; coef_wr = 1'b0; coef_idx = '0;
      coef_data = '0; shift_wr = 1'b0; shift_data = '0; commit = 1'b0; byp = 1'b0;
   endtask

   // one clock: update the reference from current inputs, clock, check outputs
   task automatic step();
      logic [12:0] r;
      logic        b;
      b = 1'b0;
`ifdef CONV_BYPASS_EN
      b = byp;
`endif
      if (valid_in) begin
         r = ref_pix(window_in, b);
         exp_q.push_back({16'(cyc + 3), last_in, r});
      end
      if (commit) begin
         ac_coef  = sh_coef;
         ac_shift = sh_shift;
         m_dirty  = 1'b0;
      end
      if (coef_wr && coef_idx <= 4'd8) begin
         sh_coef[coef_idx] = int'($signed(coef_data));
         m_dirty = 1'b1;
      end
      if (shift_wr) begin
         sh_shift = int'(shift_data);
         m_dirty  = 1'b1;
      end
      @(posedge clk);
      cyc++;
      #1;
      if (exp_q.size() > 0 && exp_q[0][29:14] == 16'(cyc)) begin
         chk("valid_out", 32'(valid_out), 32'd1);
         chk("pixel_out", 32'(pixel_out), 32'(exp_q[0][11:0]));
         chk("clip_out",  32'(clip_out),  32'(exp_q[0][12]));
         chk("last_out",  32'(last_out),  32'(exp_q[0][13]));
         void'(exp_q.pop_front());
      end else begin
         chk("valid_idle", 32'(valid_out), 32'd0);
      end
      chk("coef_dirty", 32'(coef_dirty), 32'(m_dirty));
      idle_inputs();
   endtask

   task automatic wr_coef(input int idx, input int val);
      coef_wr = 1'b1; coef_idx = 4'(idx); coef_data = 8'(val);
      step();
   endtask

   task automatic wr_shift(input int s);
      shift_wr = 1'b1; shift_data = 4'(s);
      step();
   endtask

   task automatic do_commit();
      commit = 1'b1;
      step();
   endtask

   task automatic send(input logic [107:0] w, input logic l);
      valid_in = 1'b1; window_in = w; last_in = l;
      step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // asynchronous reset asserted away from the clock edge
   task automatic do_reset();
      idle_inputs();
      reset_n = 1'b0;
      #1;
      chk("rst_valid", 32'(valid_out), 32'd0);
      chk("rst_pixel", 32'(pixel_out), 32'd0);
      chk("rst_last",  32'(last_out),  32'd0);
      chk("rst_clip",  32'(clip_out),  32'd0);
      chk("rst_dirty", 32'(coef_dirty), 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      logic [107:0] w;
      idle_inputs();
      window_in = '0;
      reset_n   = 1'b0;
      #3;
      do_reset();

      // identity kernel after reset passes the center through
      send(mk_win(12'hA5C, 12'h000, 1'b1), 1'b1);
      send(mk_win(12'h3C1, 12'h000, 1'b1), 1'b0);
      idle(3);

      // sharpen: center 9, neighbours -1
      for (int k = 0; k < 8; k++) wr_coef(k, -1);
      wr_coef(8, 9);
      do_commit();
      send(mk_win(12'h888, 12'h888, 1'b0), 1'b0);
      send(mk_win(12'hF00, 12'h000, 1'b0), 1'b1);
      send(mk_win(12'h000, 12'hFFF, 1'b0), 1'b0);
      idle(3);

      // box filter with shift 3 and rounding
      for (int k = 0; k < 9; k++) wr_coef(k, 1);
      wr_shift(3);
      do_commit();
      send(mk_win(12'h777, 12'h777, 1'b0), 1'b0);
      send(mk_win(12'h111, 12'h111, 1'b0), 1'b0);
      idle(3);

      // ignored index, then back-to-back stream with commit mid-stream
      wr_coef(12, 55);
      wr_coef(8, 2);
      wr_shift(1);
      for (int i = 0; i < 8; i++) begin
         valid_in = 1'b1; window_in = mk_win(12'($urandom), 12'h000, 1'b1);
         last_in = (i == 7);
         if (i == 4) commit = 1'b1;
         if (i == 4) begin coef_wr = 1'b1; coef_idx = 4'd0; coef_data = 8'd3; end
         step();
      end
      idle(3);
      do_commit();

      // reset with pixels in flight
      for (int k = 0; k < 9; k++) wr_coef(k, 2);
      do_commit();
      send(mk_win(12'h123, 12'h000, 1'b1), 1'b0);
      send(mk_win(12'h456, 12'h000, 1'b1), 1'b0);
      valid_in = 1'b1;
      window_in = mk_win(12'h789, 12'h000, 1'b1);
      do_reset();
      idle(4);
      send(mk_win(12'hBEE, 12'h000, 1'b1), 1'b0);
      idle(3);

`ifdef CONV_BYPASS_EN
      for (int k = 0; k < 8; k++) wr_coef(k, -2);
      wr_coef(8, 17);
      do_commit();
      byp = 1'b1;
      send(mk_win(12'h3C7, 12'h000, 1'b1), 1'b0);
      send(mk_win(12'h3C7, 12'h000, 1'b1), 1'b0);
      idle(3);
`endif

      // random stream
      for (int i = 0; i < 600; i++) begin
         valid_in  = ($urandom_range(3) != 0);
         w         = mk_win(12'($urandom), 12'h000, 1'b1);
         window_in = w;
         last_in   = 1'($urandom);
         byp       = ($urandom_range(7) == 0);
         if ($urandom_range(4) == 0) begin
            coef_wr   = 1'b1;
            coef_idx  = 4'($urandom_range(15));
            coef_data = 8'($urandom_range(0, 8) + 252);
         end
         if ($urandom_range(9) == 0) begin
            shift_wr   = 1'b1;
            shift_data = 4'($urandom_range(4));
         end
         commit = ($urandom_range(7) == 0);
         step();
      end
      idle(4);
      chk("drain", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
